// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_pkg                                                         |
// | Purpose  : Shared definitions for the PS/2 keyboard transmitter: frame     |
// |            size, FSM state encoding and frame/parity helpers.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HIGH    = 3'd1,
    ST_LOW     = 3'd2,
    ST_GAP     = 3'd3,
    ST_INHIBIT = 3'd4
  } ps2_state_t;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame word sent LSB first: bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_byte_fifo                                                   |
// | Purpose  : Synchronous 8-bit FIFO with count-based full/empty detection.   |
// |            Head byte is visible on o_data while the FIFO is non-empty.     |
// | Ports    : clk, rst_n (async active-low), i_push/i_data, i_pop,            |
// |            o_data (head), o_full, o_empty                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == (c_AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_keyboard_tx                                                 |
// | Purpose  : Device-side PS/2 keyboard transmitter. Queues scan codes on     |
// |            each rising edge of key_action and sends them as 11-bit PS/2    |
// |            frames, honouring host clock inhibit and an inter-frame gap.    |
// | Ports    : CLOCK_50, resetn (async active-low), key_action, scan_code,     |
// |            ps2_clk_inhibit -> ps2_clk, ps2_dat, busy, fifo_full, overflow  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP        = 5000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_action,
  input  logic [7:0] scan_code,
  input  logic       ps2_clk_inhibit,
  output logic       ps2_clk,
  output logic       ps2_dat,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int c_PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;

  // ---------------------------------------------------------------- key edge
  logic       r_key_q;
  logic       r_push;
  logic [7:0] r_push_data;
  logic       w_key_edge;

  assign w_key_edge = key_action & ~r_key_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_key_q     <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_key_q     <= key_action;
      r_push      <= w_key_edge;
      r_push_data <= scan_code;
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [7:0] w_head;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_pop;

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // --------------------------------------------------------------------- FSM
  ps2_state_t                r_state;
  ps2_state_t                w_state_next;
  logic [c_PHASE_W-1:0]      r_phase_cnt;
  logic [c_GAP_W-1:0]        r_gap_cnt;
  logic [3:0]                r_bit_idx;
  logic [FRAME_BITS-1:0]     r_shift;
  logic                      w_phase_done;
  logic                      w_gap_done;
  logic                      w_load;
  logic                      w_shift;

  assign w_phase_done = (r_phase_cnt == c_PHASE_W'(CLK_DIV - 1));
  assign w_gap_done   = (r_gap_cnt == c_GAP_W'(GAP - 1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !ps2_clk_inhibit) begin
          w_state_next = ST_HIGH;
          w_load       = 1'b1;
        end
      end
      ST_HIGH: begin
        if (ps2_clk_inhibit) begin
          w_state_next = ST_INHIBIT;
        end else if (w_phase_done) begin
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (ps2_clk_inhibit) begin
          w_state_next = ST_INHIBIT;
        end else if (w_phase_done) begin
          if (r_bit_idx == 4'(FRAME_BITS - 1)) begin
            // Byte is only released once its stop bit has fully gone out.
            w_state_next = ST_GAP;
            w_pop        = 1'b1;
          end else begin
            w_state_next = ST_HIGH;
            w_shift      = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (ps2_clk_inhibit || w_gap_done) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        // Aborted byte is still at the FIFO head and restarts from its start bit.
        if (!ps2_clk_inhibit) begin
          w_state_next = ST_GAP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_gap_cnt   <= '0;
      r_bit_idx   <= 4'd0;
      r_shift     <= '1;
    end else begin
      r_state <= w_state_next;

      // Phase and gap counters restart on every state change.
      if (w_state_next != r_state) begin
        r_phase_cnt <= '0;
        r_gap_cnt   <= '0;
      end else begin
        if (r_state == ST_HIGH || r_state == ST_LOW) begin
          r_phase_cnt <= r_phase_cnt + c_PHASE_W'(1);
        end
        if (r_state == ST_GAP) begin
          r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        end
      end

      if (w_load || w_state_next == ST_INHIBIT) begin
        r_bit_idx <= 4'd0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + 4'd1;
      end

      if (w_load) begin
        r_shift <= build_frame(w_head);
      end else if (w_shift) begin
        r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
      end
    end
  end

  // ------------------------------------------------------------ output regs
  // Lines follow the state one cycle later; a host inhibit overrides them
  // directly so the bus is released on the very next edge.
  logic r_ps2_clk;
  logic r_ps2_dat;
  logic r_busy;
  logic r_overflow;
  logic w_in_frame;

  assign w_in_frame = (r_state == ST_HIGH) || (r_state == ST_LOW);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_ps2_clk  <= 1'b1;
      r_ps2_dat  <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ps2_clk <= ps2_clk_inhibit | (r_state != ST_LOW);
      r_ps2_dat <= ps2_clk_inhibit | (w_in_frame ? r_shift[0] : 1'b1);
      r_busy    <= (r_state != ST_IDLE) | ~w_fifo_empty;
      if (r_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ps2_clk   = r_ps2_clk;
  assign ps2_dat   = r_ps2_dat;
  assign busy      = r_busy;
  assign fifo_full = w_fifo_full;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_keyboard_tx                                              |
// | Purpose  : Self-checking bench for ps2_keyboard_tx (CLK_DIV=4, GAP=8).     |
// |            A line monitor decodes frames and pops expected bytes from a    |
// |            scoreboard queue filled by the directed stimulus.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ps2_keyboard_tx;

  localparam int C_CLK_DIV = 4;
  localparam int C_GAP     = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       key_action = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       ps2_clk_inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  ps2_keyboard_tx #(
    .CLK_DIV    (C_CLK_DIV),
    .GAP        (C_GAP),
    .FIFO_DEPTH (8)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .key_action      (key_action),
    .scan_code       (scan_code),
    .ps2_clk_inhibit (ps2_clk_inhibit),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat),
    .busy            (busy),
    .fifo_full       (fifo_full),
    .overflow        (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ line monitor
  logic [7:0]  exp_q[$];
  logic [10:0] frame_log[$];
  int          cyc = 0;
  int          nbits = 0;
  int          frames = 0;
  int          falls = 0;
  int          t_start = 0;
  int          t_end = -1000;
  logic [10:0] fb = '0;
  logic [7:0]  exp_byte;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  logic        pending = 1'b0;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (prev_clk && !ps2_clk) falls++;
    if (!resetn || ps2_clk_inhibit) begin
      nbits   = 0;
      pending = 1'b0;
    end else begin
      if (nbits == 0 && ps2_clk && prev_dat && !ps2_dat) begin
        t_start = cyc;
        check("inter_frame_gap", 32'((cyc - t_end) >= C_GAP), 32'd1);
      end
      if (prev_clk && !ps2_clk) begin
        fb[nbits] = ps2_dat;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          frames++;
          pending = 1'b1;
          frame_log.push_back(fb);
          check("start_bit", 32'(fb[0]), 32'd0);
          check("stop_bit", 32'(fb[10]), 32'd1);
          check("parity_bit", 32'(fb[9]), 32'(~^fb[8:1]));
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_byte = exp_q.pop_front();
            check("frame_data", 32'(fb[8:1]), 32'(exp_byte));
          end
        end
      end
      if (!prev_clk && ps2_clk && pending) begin
        check("frame_len", 32'(cyc - t_start), 32'(22 * C_CLK_DIV));
        t_end   = cyc;
        pending = 1'b0;
      end
    end
    prev_clk = ps2_clk;
    prev_dat = ps2_dat;
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    scan_code  = b;
    key_action = 1'b1;
    if (expect_tx) exp_q.push_back(b);
    tick();
    key_action = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    repeat (4) tick();
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_nbits(input int n, input string tag);
    for (int i = 0; i < 500; i++) begin
      if (nbits == n) break;
      tick();
    end
    check(tag, 32'(nbits), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // --------------------------------------------------------------- stimulus
  int          f0;
  int          falls0;
  int          lat;
  int          k;
  logic [10:0] fr;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_dat", 32'(ps2_dat), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    resetn = 1'b1;
    repeat (3) tick();

    // 1: single byte 1C, latency, bit pattern, busy drop after stop
    f0 = frames;
    scan_code  = 8'h1C;
    key_action = 1'b1;
    exp_q.push_back(8'h1C);
    tick();
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ps2_dat === 1'b0) break;
    end
    key_action = 1'b0;
    check("start_latency", 32'(lat), 32'd3);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (frames > f0) break;
      tick();
    end
    check("t1_frames", 32'(frames), 32'(f0 + 1));
    fr = (frame_log.size() > 0) ? frame_log[frame_log.size()-1] : '0;
    check("t1_bits", 32'(fr), 32'h438);
    for (int i = 0; i < 20; i++) begin
      if (ps2_clk === 1'b1) break;
      tick();
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) break;
      tick();
      k++;
    end
    check("busy_low_after_stop", 32'(k), 32'(C_GAP));

    // 2: 00 then FF back to back, both parity bits 1
    repeat (5) tick();
    f0 = frames;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    wait_idle("t2_idle");
    check("t2_frames", 32'(frames), 32'(f0 + 2));
    fr = (frame_log.size() > 1) ? frame_log[frame_log.size()-2] : '0;
    check("t2_parity_00", 32'(fr[9]), 32'd1);
    fr = (frame_log.size() > 0) ? frame_log[frame_log.size()-1] : '0;
    check("t2_parity_ff", 32'(fr[9]), 32'd1);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: fill while inhibited, one extra byte overflows
    f0 = frames;
    falls0 = falls;
    ps2_clk_inhibit = 1'b1;
    for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8);
    repeat (3) tick();
    check("t3_fifo_full", 32'(fifo_full), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_clk_toggle", 32'(falls), 32'(falls0));
    ps2_clk_inhibit = 1'b0;
    wait_idle("t3_idle");
    check("t3_frames", 32'(frames), 32'(f0 + 8));
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_fifo_not_full", 32'(fifo_full), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: inhibit in LOW phase of data bit 5, byte resent once
    f0 = frames;
    push_byte(8'hF0, 1'b1);
    wait_nbits(7, "t4_reach_bit5");
    ps2_clk_inhibit = 1'b1;
    tick();
    check("t4_clk_released", 32'(ps2_clk), 32'd1);
    check("t4_dat_released", 32'(ps2_dat), 32'd1);
    falls0 = falls;
    repeat (10) tick();
    check("t4_clk_held", 32'(falls), 32'(falls0));
    ps2_clk_inhibit = 1'b0;
    wait_idle("t4_idle");
    check("t4_frames", 32'(frames), 32'(f0 + 1));
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-frame with bytes queued
    f0 = frames;
    falls0 = falls;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b0);
    push_byte(8'hA3, 1'b0);
    wait_nbits(3, "t5_mid_frame");
    resetn = 1'b0;
    #1;
    check("t5_clk", 32'(ps2_clk), 32'd1);
    check("t5_dat", 32'(ps2_dat), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (300) tick();
    check("t5_no_frame", 32'(frames), 32'(f0));
    check("t5_busy_after", 32'(busy), 32'd0);

    // 6: key_action held high for 100 cycles
    f0 = frames;
    scan_code  = 8'h5A;
    key_action = 1'b1;
    exp_q.push_back(8'h5A);
    repeat (100) tick();
    key_action = 1'b0;
    wait_idle("t6_idle");
    check("t6_frames", 32'(frames), 32'(f0 + 1));
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
